mem_ctrl: RTL and testbench

Backing-memory responder that sits below the L1 cache and serves its line-fill (read) and write-back (write) requests. Holds `MEM_DEPTH` lines of `CACHE_LEN` bytes in an internal array and answers each request after a fixed, parameterised access latency. A single outstanding request is allowed. A valid/ready request channel feeds a valid/ready response channel.

---
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Backing-memory responder below the L1: serves line fills and write-backs from an internal
// line array after a fixed access latency, one request outstanding at a time.
module mem_ctrl #(
    parameter int unsigned CACHE_LEN = 8,
    parameter int unsigned ADDR_L    = 32,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_L-1:0]      req_addr,
    input  logic [8*CACHE_LEN-1:0] req_wdata,
    input  logic [CACHE_LEN-1:0]   req_be,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_we,
    output logic                   resp_err,
    output logic [8*CACHE_LEN-1:0] resp_rdata
);

    localparam int unsigned LW = 8 * CACHE_LEN;
    localparam int unsigned OB = $clog2(CACHE_LEN);
    localparam int unsigned IB = $clog2(MEM_DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [IB-1:0] idx_q, idx_d;
    logic [LW-1:0] wdata_q, wdata_d;
    logic [CACHE_LEN-1:0] be_q, be_d;
    logic          resp_valid_q, resp_valid_d;
    logic [LW-1:0] resp_rdata_q, resp_rdata_d;

    logic [LW-1:0] mem [MEM_DEPTH];

    logic [IB-1:0] req_idx;
    logic          req_oor;
    logic          access;
    logic          commit;

    assign req_idx = req_addr[OB+IB-1:OB];

    generate
        if (OB + IB < ADDR_L) begin : g_range_check
            assign req_oor = |req_addr[ADDR_L-1:OB+IB];
        end else begin : g_no_range_check
            assign req_oor = 1'b0;
        end
        if (OB > 0) begin : g_offset
            // Line offset is deliberately dropped: every access is line-aligned.
            logic unused_offset_bits;
            assign unused_offset_bits = ^req_addr[OB-1:0];
        end
    endgenerate

    // Ready is withheld while reset is held even though the state already reads IDLE.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_we    = we_q;
    assign resp_err   = err_q;
    assign resp_rdata = resp_rdata_q;

    // The access happens on the last WAIT edge, for reads and writes alike.
    assign access = (state_q == WAIT) && (cnt_q == '0);
    assign commit = access && we_q && !err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    err_d   = req_oor;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (we_q || err_q) begin
                        resp_rdata_d = '0;
                    end else begin
                        resp_rdata_d = mem[idx_q];
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Array is not reset; a reset asserted before the commit edge forces IDLE and skips the write.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < CACHE_LEN; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, write/read, byte enables, backpressure, range errors,
// and reset during a pending write.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_we;
    logic        resp_err;
    logic [63:0] resp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_ctrl #(
        .CACHE_LEN(8),
        .ADDR_L   (32),
        .MEM_DEPTH(1024),
        .LATENCY  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_we   (resp_we),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transaction with resp_ready held high; called just after a clock edge.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be,
                        input logic [63:0] exp_rdata, input logic exp_err);
        int cyc;
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd4);
        check({tag, " resp_we"}, 64'(resp_we), 64'(we));
        check({tag, " resp_err"}, 64'(resp_err), 64'(exp_err));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, 64'(resp_valid), 64'd0);
        check({tag, " rdata clear"}, resp_rdata, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_we", 64'(resp_we), 64'd0);
        check("rst resp_err", 64'(resp_err), 64'd0);
        check("rst rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", 64'(req_ready), 64'd1);
        resp_ready = 1'b1;

        xfer("wr40", 1'b1, 32'h40, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0);
        xfer("rd40", 1'b0, 32'h40, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);
        xfer("wr40 be0f", 1'b1, 32'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, 1'b0);
        xfer("rd40 be0f", 1'b0, 32'h40, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);
        xfer("wr40 be00", 1'b1, 32'h40, 64'h5555555555555555, 8'h00, 64'd0, 1'b0);
        xfer("rd47 offset", 1'b0, 32'h47, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);

        // Backpressure: hold response, present a clobbering write that must be ignored.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp valid", 64'(resp_valid), 64'd1);
        check("bp rdata", resp_rdata, 64'h11223344AAAAAAAA);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h40;
            req_wdata = 64'd0;
            req_be    = 8'hFF;
            @(posedge clk);
            #1;
            check("bp hold valid", 64'(resp_valid), 64'd1);
            check("bp hold rdata", resp_rdata, 64'h11223344AAAAAAAA);
            check("bp hold we", 64'(resp_we), 64'd0);
            check("bp hold ready", 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", 64'(resp_valid), 64'd0);
        check("bp release rdata", resp_rdata, 64'd0);
        check("bp release ready", 64'(req_ready), 64'd1);
        xfer("rd40 after bp", 1'b0, 32'h40, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);

        // Out of range: the write would alias line 8 (0x40) if the high bits were dropped.
        xfer("rd oor", 1'b0, 32'h0001_0000, 64'd0, 8'h00, 64'd0, 1'b1);
        xfer("wr oor", 1'b1, 32'h0001_0040, 64'd0, 8'hFF, 64'd0, 1'b1);
        xfer("rd40 after oor", 1'b0, 32'h40, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);

        // Reset two cycles into a write must leave the old line intact.
        xfer("wr80", 1'b1, 32'h80, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h80;
        req_wdata = 64'hDEADBEEFDEADBEEF;
        req_be    = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("midwr ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midwr rst ready", 64'(req_ready), 64'd0);
        check("midwr rst valid", 64'(resp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midwr post ready", 64'(req_ready), 64'd1);
        xfer("rd80 after rst", 1'b0, 32'h80, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0);
        xfer("rd40 persists", 1'b0, 32'h40, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
